// File: rtl/fetch_if.sv
// Fetch-stage bundle: memory read port, PC redirect and the instruction handoff.
// Handshake: the instruction transfers on any clock edge where instr_valid and
// instr_ready are both 1; while instr_valid is 1 its payload holds steady.
interface fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;

    modport master (
        output mem_addr, mem_rd, instr_valid, opcode, operand, instr_len, instr_pc,
        input  mem_rdata, pc_load, pc_new, instr_ready
    );

    modport slave (
        input  mem_addr, mem_rd, instr_valid, opcode, operand, instr_len, instr_pc,
        output mem_rdata, pc_load, pc_new, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// 6502 instruction fetch: reads the reset vector, then fetches opcode plus
// 0-2 operand bytes per instruction and hands each one to the control stage.
module fetch_unit #(
    parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     bus,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        VEC_LO_ISSUE, VEC_LO_CAPT, VEC_HI_ISSUE, VEC_HI_CAPT,
        ISSUE_OP, CAPT_OP, ISSUE_LO, CAPT_LO, ISSUE_HI, CAPT_HI, HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [1:0]  instr_len_q, instr_len_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        in_vector;

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd2;
        if (op[3:0] == 4'h8 || op[3:0] == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60)
            len = 2'd1;
        if (op[3:2] == 2'b11 || op[4:0] == 5'b11001 || op == 8'h20)
            len = 2'd3;
        return len;
    endfunction

    assign in_vector = (state_q == VEC_LO_ISSUE) || (state_q == VEC_LO_CAPT) ||
                       (state_q == VEC_HI_ISSUE) || (state_q == VEC_HI_CAPT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        instr_len_d = instr_len_q;
        instr_pc_d  = instr_pc_q;
        case (state_q)
            VEC_LO_ISSUE: state_d = VEC_LO_CAPT;
            VEC_LO_CAPT: begin
                pc_d[7:0] = bus.mem_rdata;
                state_d   = VEC_HI_ISSUE;
            end
            VEC_HI_ISSUE: state_d = VEC_HI_CAPT;
            VEC_HI_CAPT: begin
                pc_d[15:8] = bus.mem_rdata;
                state_d    = ISSUE_OP;
            end
            ISSUE_OP: begin
                pc_d    = pc_q + 16'd1;
                state_d = CAPT_OP;
            end
            CAPT_OP: begin
                // pc already advanced past the opcode during ISSUE_OP
                opcode_d    = bus.mem_rdata;
                instr_pc_d  = pc_q - 16'd1;
                operand_d   = 16'h0000;
                instr_len_d = decode_len(bus.mem_rdata);
                state_d     = (decode_len(bus.mem_rdata) == 2'd1) ? HOLD : ISSUE_LO;
            end
            ISSUE_LO: begin
                pc_d    = pc_q + 16'd1;
                state_d = CAPT_LO;
            end
            CAPT_LO: begin
                operand_d[7:0] = bus.mem_rdata;
                state_d        = (instr_len_q == 2'd2) ? HOLD : ISSUE_HI;
            end
            ISSUE_HI: begin
                pc_d    = pc_q + 16'd1;
                state_d = CAPT_HI;
            end
            CAPT_HI: begin
                operand_d[15:8] = bus.mem_rdata;
                state_d         = HOLD;
            end
            HOLD: if (bus.instr_ready) state_d = ISSUE_OP;
            default: state_d = VEC_LO_ISSUE;
        endcase
        // A redirect drops any partially fetched bytes and keeps the old payload
        if (bus.pc_load && !in_vector) begin
            pc_d        = bus.pc_new;
            state_d     = ISSUE_OP;
            opcode_d    = opcode_q;
            operand_d   = operand_q;
            instr_len_d = instr_len_q;
            instr_pc_d  = instr_pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= VEC_LO_ISSUE;
            pc_q        <= 16'h0000;
            opcode_q    <= 8'h00;
            operand_q   <= 16'h0000;
            instr_len_q <= 2'd1;
            instr_pc_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            instr_len_q <= instr_len_d;
            instr_pc_q  <= instr_pc_d;
        end
    end

    // Reset state is an ISSUE state, so the strobe is gated by reset itself
    assign bus.mem_rd = reset && ((state_q == VEC_LO_ISSUE) || (state_q == VEC_HI_ISSUE) ||
                                  (state_q == ISSUE_OP) || (state_q == ISSUE_LO) ||
                                  (state_q == ISSUE_HI));

    always_comb begin
        bus.mem_addr = pc_q;
        if (state_q == VEC_LO_ISSUE || state_q == VEC_LO_CAPT)
            bus.mem_addr = VECTOR_ADDR;
        else if (state_q == VEC_HI_ISSUE || state_q == VEC_HI_CAPT)
            bus.mem_addr = VECTOR_ADDR + 16'd1;
    end

    assign bus.instr_valid = (state_q == HOLD);
    assign bus.opcode      = opcode_q;
    assign bus.operand     = operand_q;
    assign bus.instr_len   = instr_len_q;
    assign bus.instr_pc    = instr_pc_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: synchronous memory model, hand-computed
// fetch address sequences and delivered instructions.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic [3:0] state_dbg;
    int         err_cnt;
    int         chk_cnt;
    logic [7:0] mem [0:65535];

    fetch_if bus ();

    fetch_unit #(.VECTOR_ADDR(16'hFFFC)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memory: data valid the cycle after mem_rd
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_fetch(input logic [15:0] addr);
        check_eq("issue_rd", 32'(bus.mem_rd), 32'd1);
        check_eq("issue_addr", 32'(bus.mem_addr), 32'(addr));
        check_eq("issue_nvalid", 32'(bus.instr_valid), 32'd0);
        step();
        check_eq("capt_rd", 32'(bus.mem_rd), 32'd0);
        step();
    endtask

    task automatic expect_instr(input logic [7:0] op, input logic [15:0] opnd,
                                input logic [1:0] len, input logic [15:0] pc);
        check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
        check_eq("hold_rd", 32'(bus.mem_rd), 32'd0);
        check_eq("opcode", 32'(bus.opcode), 32'(op));
        check_eq("operand", 32'(bus.operand), 32'(opnd));
        check_eq("instr_len", 32'(bus.instr_len), 32'(len));
        check_eq("instr_pc", 32'(bus.instr_pc), 32'(pc));
        step();
    endtask

    task automatic check_reset_vals();
        check_eq("rst_rd", 32'(bus.mem_rd), 32'd0);
        check_eq("rst_addr", 32'(bus.mem_addr), 32'hFFFC);
        check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_opcode", 32'(bus.opcode), 32'd0);
        check_eq("rst_operand", 32'(bus.operand), 32'd0);
        check_eq("rst_len", 32'(bus.instr_len), 32'd1);
        check_eq("rst_pc", 32'(bus.instr_pc), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        err_cnt         = 0;
        chk_cnt         = 0;
        reset           = 1'b0;
        bus.instr_ready = 1'b1;
        bus.pc_load     = 1'b0;
        bus.pc_new      = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h02;
        mem[16'h0200] = 8'h69; mem[16'h0201] = 8'h05;
        mem[16'h0202] = 8'h6D; mem[16'h0203] = 8'h34; mem[16'h0204] = 8'h12;
        mem[16'h0205] = 8'hE8;
        mem[16'h0206] = 8'hAD; mem[16'h0207] = 8'h00; mem[16'h0208] = 8'h03;
        mem[16'h0300] = 8'hA9; mem[16'h0301] = 8'h42;
        mem[16'h0400] = 8'h60;
        mem[16'h0401] = 8'h4C; mem[16'h0402] = 8'h11; mem[16'h0403] = 8'h22;

        repeat (3) step();
        check_reset_vals();
        reset = 1'b1;
        #1;

        // Vector, then 2-byte and 3-byte instructions back to back
        expect_fetch(16'hFFFC);
        expect_fetch(16'hFFFD);
        expect_fetch(16'h0200);
        expect_fetch(16'h0201);
        expect_instr(8'h69, 16'h0005, 2'd2, 16'h0200);
        expect_fetch(16'h0202);
        expect_fetch(16'h0203);
        expect_fetch(16'h0204);
        expect_instr(8'h6D, 16'h1234, 2'd3, 16'h0202);

        // Back-pressure: ready low for 5 cycles in HOLD
        bus.instr_ready = 1'b0;
        expect_fetch(16'h0205);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(bus.instr_valid), 32'd1);
            check_eq("stall_rd", 32'(bus.mem_rd), 32'd0);
            check_eq("stall_opcode", 32'(bus.opcode), 32'hE8);
            check_eq("stall_operand", 32'(bus.operand), 32'h0000);
            check_eq("stall_len", 32'(bus.instr_len), 32'd1);
            check_eq("stall_pc", 32'(bus.instr_pc), 32'h0205);
            check_eq("stall_addr", 32'(bus.mem_addr), 32'h0206);
            step();
        end
        bus.instr_ready = 1'b1;
        expect_instr(8'hE8, 16'h0000, 2'd1, 16'h0205);

        // Redirect during CAPT_LO of a 3-byte instruction
        expect_fetch(16'h0206);
        check_eq("lo_rd", 32'(bus.mem_rd), 32'd1);
        check_eq("lo_addr", 32'(bus.mem_addr), 32'h0207);
        step();
        check_eq("capt_lo_nvalid", 32'(bus.instr_valid), 32'd0);
        bus.pc_load = 1'b1;
        bus.pc_new  = 16'h0300;
        step();
        bus.pc_load = 1'b0;
        check_eq("redir_nvalid", 32'(bus.instr_valid), 32'd0);
        expect_fetch(16'h0300);
        expect_fetch(16'h0301);

        // Redirect together with the HOLD handshake
        bus.pc_load = 1'b1;
        bus.pc_new  = 16'h0400;
        expect_instr(8'hA9, 16'h0042, 2'd2, 16'h0300);
        bus.pc_load = 1'b0;
        expect_fetch(16'h0400);
        expect_instr(8'h60, 16'h0000, 2'd1, 16'h0400);

        // Reset pulsed in ISSUE_HI, then a wrapping vector target
        expect_fetch(16'h0401);
        expect_fetch(16'h0402);
        check_eq("hi_rd", 32'(bus.mem_rd), 32'd1);
        check_eq("hi_addr", 32'(bus.mem_addr), 32'h0403);
        reset = 1'b0;
        #1;
        check_reset_vals();
        mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF;
        mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h7F;
        mem[16'h0001] = 8'h20; mem[16'h0002] = 8'hCD; mem[16'h0003] = 8'hAB;
        step();
        step();
        reset = 1'b1;
        #1;
        // pc_load must be ignored while reading the vector
        bus.pc_load = 1'b1;
        bus.pc_new  = 16'h0500;
        expect_fetch(16'hFFFC);
        bus.pc_load = 1'b0;
        expect_fetch(16'hFFFD);
        expect_fetch(16'hFFFF);
        expect_fetch(16'h0000);
        expect_instr(8'hA9, 16'h007F, 2'd2, 16'hFFFF);
        expect_fetch(16'h0001);
        expect_fetch(16'h0002);
        expect_fetch(16'h0003);
        expect_instr(8'h20, 16'hABCD, 2'd3, 16'h0001);
        check_eq("next_rd", 32'(bus.mem_rd), 32'd1);
        check_eq("next_addr", 32'(bus.mem_addr), 32'h0004);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 6502 core, directly upstream of `instruction_control`. After reset it reads the reset vector and loads the program counter, then fetches each instruction as opcode plus 0–2 operand bytes over a single-port synchronous memory interface. It presents the assembled instruction to the control stage through a valid/ready handshake, and accepts PC redirects from the control stage for jumps, branches and interrupts.

## Interface
- `VECTOR_ADDR`, default 16'hFFFC. Address of the reset-vector low byte; the high byte is at `VECTOR_ADDR+1`.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `mem_addr`  out  16  read address
- `mem_rd`  out  1  read strobe
- `mem_rdata`  in  8  read data, valid exactly one cycle after `mem_rd`
- `pc_load`  in  1  redirect request
- `pc_new`  in  16  redirect target
- `instr_valid`  out  1  instruction available
- `instr_ready`  in  1  control stage accepts the instruction
- `opcode`  out  8  fetched opcode
- `operand`  out  16  [7:0] first operand byte, [15:8] second; bytes not fetched read as 0
- `instr_len`  out  2  byte count, 1–3
- `instr_pc`  out  16  address of the opcode

## Operation
- States: VEC_LO_ISSUE, VEC_LO_CAPT, VEC_HI_ISSUE, VEC_HI_CAPT, ISSUE_OP, CAPT_OP, ISSUE_LO, CAPT_LO, ISSUE_HI, CAPT_HI, HOLD.
- ISSUE states drive `mem_rd`=1. The address is `VECTOR_ADDR` or `VECTOR_ADDR+1` in the vector states and `pc` otherwise. Each ISSUE state increments `pc`, except the vector states.
- CAPT states drive `mem_rd`=0 and register `mem_rdata`:
  - VEC_LO_CAPT loads `pc[7:0]`; VEC_HI_CAPT loads `pc[15:8]` and goes to ISSUE_OP.
  - CAPT_OP latches `opcode` and `instr_pc`, clears `operand`, and decodes the length.
  - CAPT_LO/CAPT_HI write `operand[7:0]`/`operand[15:8]`.
- Length decode on the captured opcode:
  - 3 bytes if `op[3:2]`=11, or `op[4:0]`=11001, or op=8'h20.
  - 1 byte if `op[3:0]` is 8 or A, or op is 00, 40 or 60.
  - Otherwise 2 bytes.
- Next state after CAPT_OP: len 1 → HOLD, otherwise ISSUE_LO. After CAPT_LO: len 2 → HOLD, otherwise ISSUE_HI. After CAPT_HI → HOLD.
- `instr_valid` = (state==HOLD). HOLD persists until `instr_valid & instr_ready`, then goes to ISSUE_OP. All outputs stay stable and `mem_rd`=0 throughout HOLD.
- Redirect: `pc_load`=1 at a clock edge in any non-vector state sets `pc`←`pc_new` and state←ISSUE_OP, discarding partial bytes.
  - A redirect coinciding with a HOLD handshake still counts as a completed transfer.
  - `pc_load` is ignored in the vector states.
- `pc` and every fetch address wrap modulo 2^16 (FFFF+1 = 0000).
- Reset (asynchronous): state=VEC_LO_ISSUE, `pc`=0, `opcode`=0, `operand`=0, `instr_len`=1, `instr_pc`=0, `instr_valid`=0. `mem_rd` is forced 0 and `mem_addr`=`VECTOR_ADDR` while `reset`=0. Reset mid-fetch abandons all state and restarts the vector read.

## Timing
- One byte costs 2 cycles: ISSUE, then CAPT.
- From reset release to the first ISSUE_OP: 4 cycles.
- ISSUE_OP to `instr_valid`: 2, 4 or 6 cycles for 1-, 2- or 3-byte instructions.
- Handshake at edge N: ISSUE_OP is in cycle N+1, so `instr_valid` drops for at least 2 cycles. There is no prefetch.
- A redirect at edge N puts ISSUE_OP with `mem_addr`=`pc_new` in cycle N+1.

## Test plan
- Memory FFFC=00, FFFD=02, 0200=69, 0201=05; `instr_ready`=1 → first `mem_rd` at 0200 on the 5th cycle after reset release. `instr_valid` asserts 4 cycles later with opcode=69, operand=0005, len=2, instr_pc=0200.
- 0202=6D, 0203=34, 0204=12, then 0205=E8 → operand=1234, len=3, then opcode=E8, operand=0000, len=1, instr_pc=0205. Every `mem_addr` matches the byte sequence.
- `instr_ready` held 0 for 5 cycles during HOLD → all outputs constant, `mem_rd`=0, no `pc` advance. Raising `instr_ready` gives ISSUE_OP the next cycle.
- `pc_load`=1 with `pc_new`=0300 during CAPT_LO of a 3-byte instruction → no `instr_valid` for it. The next fetch is at 0300; the delivered `instr_pc`=0300.
- Vector = FFFF, FFFF=A9, 0000=7F → fetch addresses FFFF then 0000; opcode=A9, operand=007F, next opcode fetched from 0001.
- `reset` pulsed low during ISSUE_HI → outputs return to reset values immediately. After release, vector fetch repeats and fetching restarts at the vector target.
